// File: rtl/fc_mac_sequencer_pkg.sv
// Shared types, defaults and sign-magnitude helpers
// for the fully-connected MAC sequencer.
package fc_mac_sequencer_pkg;

    localparam int WIDTH_D  = 16;
    localparam int FRAC_D   = 10;
    localparam int ADDR_W_D = 10;
    localparam int ACC_W_D  = 32;

    localparam logic [WIDTH_D-1:0] SM_MAX = WIDTH_D'((1 << (WIDTH_D - 1)) - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    // Sign-magnitude word to sign-extended two's complement.
    function automatic logic signed [ACC_W_D-1:0] sm_to_tc(
        input logic [WIDTH_D-1:0] sm
    );
        logic signed [ACC_W_D-1:0] mag;
        mag = signed'({{(ACC_W_D-WIDTH_D+1){1'b0}}, sm[WIDTH_D-2:0]});
        return sm[WIDTH_D-1] ? -mag : mag;
    endfunction

    // Saturate to +/-SM_MAX and encode as sign-magnitude (zero -> 0x0000).
    function automatic logic [WIDTH_D-1:0] tc_sat_to_sm(
        input logic signed [ACC_W_D-1:0] v
    );
        logic signed [ACC_W_D-1:0] lim;
        logic signed [ACC_W_D-1:0] neg;
        lim = signed'({{(ACC_W_D-WIDTH_D+1){1'b0}}, SM_MAX[WIDTH_D-2:0]});
        neg = -v;
        if (v > lim) begin
            return {1'b0, SM_MAX[WIDTH_D-2:0]};
        end else if (v < -lim) begin
            return {1'b1, SM_MAX[WIDTH_D-2:0]};
        end else if (v < 0) begin
            return {1'b1, neg[WIDTH_D-2:0]};
        end else begin
            return {1'b0, v[WIDTH_D-2:0]};
        end
    endfunction

endpackage

// File: rtl/fixed_point_MUL.sv
// Combinational sign-magnitude fixed-point multiplier.
// Magnitude is truncated to WIDTH-1 bits, no saturation.
module fixed_point_MUL #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [2*WIDTH-3:0] full;
    logic               unused_bits;

    assign full        = a[WIDTH-2:0] * b[WIDTH-2:0];
    assign y           = {a[WIDTH-1] ^ b[WIDTH-1], full[FRAC+WIDTH-2:FRAC]};
    assign unused_bits = ^{full[FRAC-1:0], full[2*WIDTH-3:FRAC+WIDTH-1]};

endmodule

// File: rtl/fc_mac_sequencer.sv
// Dot-product sequencer for one neuron: fetch, multiply,
// accumulate with bias, optional ReLU, saturate to sign-magnitude.
module fc_mac_sequencer
    import fc_mac_sequencer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_D,
    parameter int FRAC   = FRAC_D,
    parameter int ADDR_W = ADDR_W_D,
    parameter int ACC_W  = ACC_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] act_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [WIDTH-1:0]  bias,
    input  logic              relu_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] act_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [WIDTH-1:0]  act_data,
    input  logic [WIDTH-1:0]  wgt_data,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result
);

    state_t                   state_q;
    state_t                   state_d;
    logic [ADDR_W-1:0]        len_q;
    logic [ADDR_W-1:0]        act_base_q;
    logic [ADDR_W-1:0]        wgt_base_q;
    logic [ADDR_W-1:0]        idx_q;
    logic                     relu_q;
    logic                     rd_valid_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [WIDTH-1:0]         prod;
    logic signed [ACC_W-1:0]  prod_tc;
    logic signed [ACC_W-1:0]  relu_v;

    fixed_point_MUL #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) u_mul (
        .a(act_data),
        .b(wgt_data),
        .y(prod)
    );

    assign prod_tc  = sm_to_tc(prod);
    assign relu_v   = (relu_q && acc_q < 0) ? '0 : acc_q;
    assign busy     = (state_q != IDLE);
    assign act_addr = mem_rd_en ? act_base_q + idx_q : '0;
    assign wgt_addr = mem_rd_en ? wgt_base_q + idx_q : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and read-strobe decode.
    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                mem_rd_en = 1'b1;
                if (idx_q == len_q - ADDR_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, index counter, accumulator and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            act_base_q <= '0;
            wgt_base_q <= '0;
            relu_q     <= 1'b0;
            idx_q      <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            rd_valid_q <= mem_rd_en;
            done       <= (state_q == FINISH);
            if (state_q == IDLE && start) begin
                len_q      <= len;
                act_base_q <= act_base;
                wgt_base_q <= wgt_base;
                relu_q     <= relu_en;
                idx_q      <= '0;
                acc_q      <= sm_to_tc(bias);
            end else if (rd_valid_q) begin
                acc_q <= acc_q + prod_tc;
            end
            if (state_q == RUN) begin
                idx_q <= idx_q + ADDR_W'(1);
            end
            if (state_q == FINISH) begin
                result <= tc_sat_to_sm(relu_v);
            end
        end
    end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Self-checking bench for fc_mac_sequencer: directed table,
// hand sequences and randomized ops against a dot-product model.
module tb_fc_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  len;
    logic [9:0]  act_base;
    logic [9:0]  wgt_base;
    logic [15:0] bias;
    logic        relu_en;
    logic        mem_rd_en;
    logic [9:0]  act_addr;
    logic [9:0]  wgt_addr;
    logic [15:0] act_data;
    logic [15:0] wgt_data;
    logic        busy;
    logic        done;
    logic [15:0] result;

    logic [15:0] act_mem [1024];
    logic [15:0] wgt_mem [1024];

    int total = 0;
    int bad   = 0;

    fc_mac_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .act_base (act_base),
        .wgt_base (wgt_base),
        .bias     (bias),
        .relu_en  (relu_en),
        .mem_rd_en(mem_rd_en),
        .act_addr (act_addr),
        .wgt_addr (wgt_addr),
        .act_data (act_data),
        .wgt_data (wgt_data),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Synchronous memories: data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            act_data <= act_mem[act_addr];
            wgt_data <= wgt_mem[wgt_addr];
        end
    end

    typedef struct packed {
        logic [9:0]       n;
        logic [9:0]       ab;
        logic [9:0]       wb;
        logic [15:0]      bias;
        logic             relu;
        logic [0:2][15:0] act;
        logic [0:2][15:0] wgt;
        logic [15:0]      exp_res;
        logic [7:0]       exp_lat;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Dot product from the arithmetic rules, in plain integers.
    function automatic logic [15:0] model(input int n, input int ab,
                                          input int wb, input logic [15:0] b,
                                          input bit r);
        longint acc;
        longint m;
        logic [15:0] a;
        logic [15:0] w;
        logic [14:0] mag;
        acc = longint'(b[14:0]);
        if (b[15]) acc = -acc;
        for (int i = 0; i < n; i++) begin
            a = act_mem[(ab + i) % 1024];
            w = wgt_mem[(wb + i) % 1024];
            m = (longint'(a[14:0]) * longint'(w[14:0])) >> 10;
            m = m % 32768;
            if (a[15] ^ w[15]) acc = acc - m;
            else               acc = acc + m;
        end
        if (r && acc < 0) acc = 0;
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32767) return 16'hFFFF;
        mag = (acc < 0) ? 15'(-acc) : 15'(acc);
        return {acc < 0, mag};
    endfunction

    // Called at a negedge; starts an op and follows it to done.
    task automatic run_op(input int n, input int ab, input int wb,
                          input logic [15:0] b, input bit r,
                          input bit inject, input int extra,
                          output logic [15:0] res, output int lat,
                          output int rds, output int dones,
                          output int addr_err);
        len      = 10'(n);
        act_base = 10'(ab);
        wgt_base = 10'(wb);
        bias     = b;
        relu_en  = r;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat      = -1;
        rds      = 0;
        dones    = 0;
        addr_err = 0;
        res      = '0;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(negedge clk);
            if (inject) begin
                start = (k == 2);
                if (k == 2) begin
                    len  = 10'd1;
                    bias = 16'h1234;
                end
            end
            if (mem_rd_en) begin
                if (act_addr != 10'(ab + rds) || wgt_addr != 10'(wb + rds))
                    addr_err++;
                rds++;
            end
            if (done) begin
                lat   = k;
                res   = result;
                dones = 1;
            end
        end
        for (int k = 0; k < extra; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dones++;
            if (mem_rd_en) rds++;
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 3; i++) begin
            act_mem[(int'(v.ab) + i) % 1024] = v.act[i];
            wgt_mem[(int'(v.wb) + i) % 1024] = v.wgt[i];
        end
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] exp;
        int lat, rds, dones, aerr, n, ab, wb, cnt;
        logic [15:0] rb;
        bit rr;

        tbl[0] = '{10'd3, 10'h010, 10'h020, 16'h0000, 1'b0,
                   {16'h0400, 16'h0800, 16'h0200},
                   {16'h0400, 16'h0400, 16'h8400}, 16'h0A00, 8'd6};
        tbl[1] = '{10'd2, 10'h040, 10'h050, 16'h0400, 1'b0,
                   {16'h7C00, 16'h7C00, 16'h0000},
                   {16'h0400, 16'h0400, 16'h0000}, 16'h7FFF, 8'd5};
        tbl[2] = '{10'd2, 10'h040, 10'h060, 16'h0400, 1'b0,
                   {16'h7C00, 16'h7C00, 16'h0000},
                   {16'h8400, 16'h8400, 16'h0000}, 16'hFFFF, 8'd5};
        tbl[3] = '{10'd0, 10'h000, 10'h000, 16'h8300, 1'b0,
                   {16'h0000, 16'h0000, 16'h0000},
                   {16'h0000, 16'h0000, 16'h0000}, 16'h8300, 8'd2};
        tbl[4] = '{10'd0, 10'h000, 10'h000, 16'h8300, 1'b1,
                   {16'h0000, 16'h0000, 16'h0000},
                   {16'h0000, 16'h0000, 16'h0000}, 16'h0000, 8'd2};
        tbl[5] = '{10'd2, 10'h3FF, 10'h100, 16'h0000, 1'b0,
                   {16'h0000, 16'h0000, 16'h0000},
                   {16'h8400, 16'h8400, 16'h0000}, 16'h0000, 8'd5};
        tbl[6] = '{10'd1, 10'h200, 10'h210, 16'h0000, 1'b1,
                   {16'h0400, 16'h0000, 16'h0000},
                   {16'h8800, 16'h0000, 16'h0000}, 16'h0000, 8'd4};

        for (int i = 0; i < 1024; i++) begin
            act_mem[i] = '0;
            wgt_mem[i] = '0;
        end
        act_data = '0;
        wgt_data = '0;
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        act_base = '0;
        wgt_base = '0;
        bias     = '0;
        relu_en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset rd_en", mem_rd_en, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset addrs", {act_addr, wgt_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            load(tbl[i]);
            run_op(int'(tbl[i].n), int'(tbl[i].ab), int'(tbl[i].wb),
                   tbl[i].bias, tbl[i].relu, 1'b0, 2,
                   res, lat, rds, dones, aerr);
            chk($sformatf("vec%0d result", i), res, tbl[i].exp_res);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d rd_en cycles", i), rds, tbl[i].n);
            chk($sformatf("vec%0d addr", i), aerr, 0);
            chk($sformatf("vec%0d done count", i), dones, 1);
        end

        // Start while busy: ignored, one done, first result kept.
        load(tbl[0]);
        run_op(4, 16'h010, 16'h020, 16'h0000, 1'b0, 1'b1, 6,
               res, lat, rds, dones, aerr);
        chk("busy start result", res, model(4, 16'h010, 16'h020, 16'h0000, 0));
        chk("busy start latency", lat, 7);
        chk("busy start dones", dones, 1);
        chk("busy start rd_en", rds, 4);

        // Reset in the middle of a long run.
        chk("pre-reset result", result, model(4, 16'h010, 16'h020, 16'h0000, 0));
        len      = 10'd8;
        act_base = 10'h010;
        wgt_base = 10'h020;
        bias     = 16'h0100;
        relu_en  = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-run busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort rd_en", mem_rd_en, 0);
        chk("abort result", result, 0);
        chk("abort done", done, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abort no done", cnt, 0);
        run_op(3, 16'h010, 16'h020, 16'h0000, 1'b0, 1'b0, 0,
               res, lat, rds, dones, aerr);
        chk("after abort result", res, 16'h0A00);
        chk("after abort latency", lat, 6);

        // Randomized back-to-back ops against the model.
        for (int t = 0; t < 40; t++) begin
            n  = $urandom_range(0, 12);
            ab = $urandom_range(0, 1023);
            wb = $urandom_range(0, 1023);
            rb = 16'($urandom);
            rr = 1'($urandom);
            for (int i = 0; i < n; i++) begin
                act_mem[(ab + i) % 1024] = 16'($urandom);
                wgt_mem[(wb + i) % 1024] = 16'($urandom);
                if ($urandom_range(0, 3) == 0)
                    act_mem[(ab + i) % 1024] = {1'($urandom), 5'd0, 10'($urandom)};
            end
            exp = model(n, ab, wb, rb, rr);
            run_op(n, ab, wb, rb, rr, 1'b0, 0, res, lat, rds, dones, aerr);
            chk($sformatf("rand%0d result", t), res, exp);
            chk($sformatf("rand%0d latency", t), lat, (n == 0) ? 2 : n + 3);
            chk($sformatf("rand%0d rd/addr", t), {rds, aerr}, {n, 0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_mac_sequencer.md
Name: fc_mac_sequencer

Overview:
Sequences one shared 16-bit sign-magnitude fixed-point multiplier (1 sign bit, 15-bit magnitude, FRAC fractional bits) over a length-N dot product for one fully-connected neuron.
- Fetches activation/weight pairs from two synchronous ROM/RAM ports.
- Accumulates products in a wide two's-complement register, seeded with a bias.
- Applies optional ReLU, then saturates and returns a sign-magnitude result.
- Sits between the layer controller (start/done) and the weight/activation memories.

Parameters:
WIDTH, 16, data word width (sign-magnitude)
FRAC, 10, fractional bits of the data format
ADDR_W, 10, memory address width; also width of len
ACC_W, 32, accumulator width (two's complement), must be >= WIDTH+ADDR_W

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
len  in  ADDR_W  number of terms N, latched at start; 0 legal
act_base  in  ADDR_W  activation base address, latched at start
wgt_base  in  ADDR_W  weight base address, latched at start
bias  in  WIDTH  sign-magnitude bias, latched at start
relu_en  in  1  clamp negative result to 0, latched at start
mem_rd_en  out  1  read strobe to both memories
act_addr  out  ADDR_W  activation read address
wgt_addr  out  ADDR_W  weight read address
act_data  in  WIDTH  activation, valid exactly 1 cycle after mem_rd_en
wgt_data  in  WIDTH  weight, valid exactly 1 cycle after mem_rd_en
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  sign-magnitude result, held until next done

Behaviour:
- Reset: state=IDLE, acc=0, idx=0, rd_valid_d=0. Outputs: mem_rd_en=0, addrs=0, busy=0, done=0, result=0.
- Reset mid-operation aborts with no done pulse; result returns to 0.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE, start=1:
  - latch inputs; acc <= sign-extended two's-complement of bias; idx <= 0.
  - go to FINISH if len==0, else RUN.
  - start while busy is ignored and not queued.
- RUN:
  - mem_rd_en=1; act_addr=act_base+idx; wgt_addr=wgt_base+idx (mod 2^ADDR_W, wraps silently); idx++.
  - when idx==len-1, go to DRAIN.
- rd_valid_d <= mem_rd_en.
- When rd_valid_d=1, product computed via the multiplier:
  - sign = a[15]^b[15].
  - mag = bits [FRAC+WIDTH-2:FRAC] of a[14:0]*b[14:0] (truncation; upper bits discarded, no saturation at multiplier).
  - acc <= acc + mag if sign=0, else acc - mag.
  - Negative zero (mag=0, sign=1) contributes 0.
- DRAIN: one cycle; the final product accumulates here; go to FINISH.
- FINISH:
  - v = (relu_en && acc<0) ? 0 : acc.
  - Saturate v to ±(2^(WIDTH-1)-1) and convert to sign-magnitude; zero always encodes as 0x0000.
  - result <= converted v; done <= 1 for the next cycle; go to IDLE.
- Latency from start-sampling edge to done high:
  - N+3 cycles for N>=1;
  - 2 cycles for N=0.
  - Back-to-back: start may be asserted in the same cycle done is high (FSM is in IDLE).
- Accumulator never overflows for N < 2^ADDR_W given the ACC_W constraint.

Decomposition:
- Shared package: WIDTH/FRAC defaults, FSM state encoding, SM_MAX = 2^(WIDTH-1)-1, and helper functions sm_to_tc / tc_sat_to_sm.
- Sub-module: a single instance of the team's existing combinational fixed_point_MUL (WIDTH=16), driven directly from act_data/wgt_data.
- Sequencer contains FSM, address counter, accumulator, and output conversion.

Test Plan:
- Basic sum. Setup: len=3, act=[0x0400,0x0800,0x0200], wgt=[0x0400,0x0400,0x8400], bias=0. Expect: result=0x0A00 (2.5), done high exactly at cycle 6, rd_en high cycles 1-3, addresses base+0..2.
- Positive saturation. Setup: len=2, act=[0x7C00,0x7C00], wgt=[0x0400,0x0400], bias=0x0400. Expect: result=0x7FFF.
  - Same with wgt=0x8400. Expect: result=0xFFFF.
- Zero length. Setup: len=0, bias=0x8300, relu_en=0. Expect: result=0x8300, done at cycle 2, no rd_en.
  - Same with relu_en=1. Expect: result=0x0000.
- Negative zero and wrap. Setup: act_base=0x3FF, len=2 (addresses 0x3FF, 0x000), act=[0x0000,0x0000], wgt=[0x8400,0x8400], bias=0. Expect: result=0x0000.
- Start while busy. Setup: pulse start again during RUN with different len/bias. Expect: ignored, first result unchanged, exactly one done.
- Reset mid-run. Setup: rst=1 during RUN of len=8. Expect: next cycle busy=0, rd_en=0, result=0, no done. A fresh start then completes normally.
